rom_addr_seq: RTL and testbench

Sequencer that sits directly upstream of the 8x4 ROM. It drives the ROM's 3-bit `addr` port and captures the combinational 4-bit `data` word into a register. It then presents each word downstream on a valid/ready handshake. One pass covers words 0..7, either once or looping continuously, and a one-cycle `step_en` tick paces the fetches so the lab board can slow the sweep for display.

---
 rtl/rom_seq_pkg.sv | 22 ++
 rtl/rom8x4.sv | 24 ++
 rtl/rom_addr_seq.sv | 115 +++++++++++
 tb/tb_rom_addr_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_seq_pkg
//  Description : Shared constants for the ROM address sequencer: FSM state
//                encoding and default ROM geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_seq_pkg;

  // Default ROM geometry (8 words x 4 bits)
  localparam int AW_DEFAULT = 3;
  localparam int DW_DEFAULT = 4;

  // Sequencer state encoding
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t HOLD  = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage : rom_seq_pkg
`default_nettype wire

// File: rtl/rom8x4.sv
`default_nettype none
// ============================================================================
//  Module      : rom8x4
//  Description : Combinational lab ROM holding the standard image where
//                word i = 2*i (0x0, 0x2, ... 0xE).
//  Ports       : addr - word address in
//                data - combinational word out
//  Revision    : 1.0 - initial release
// ============================================================================
module rom8x4
  import rom_seq_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  // word i = 2*i, i.e. the address shifted left by one
  assign data = DW'({addr, 1'b0});

endmodule : rom8x4
`default_nettype wire

// File: rtl/rom_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rom_addr_seq
//  Description : Sweeps a combinational ROM from word 0 to word 2^AW-1,
//                captures each word and offers it downstream on a
//                valid/ready handshake. Single-pass or continuous looping,
//                with fetches paced by a one-cycle step_en tick.
//  Ports       : clk, rst_n      - clock, asynchronous active-low reset
//                start           - begin a pass (sampled in IDLE only)
//                stop            - synchronous abort (any non-IDLE state)
//                mode_loop       - 1 = wrap last word back to 0 forever
//                step_en         - fetch pacing tick
//                addr            - registered ROM address
//                rom_data        - combinational ROM word for addr
//                dout/dout_valid - captured word and its valid flag
//                dout_ready      - downstream accept
//                busy            - high in FETCH and HOLD
//                done            - one-cycle pulse at end of a single pass
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_addr_seq
  import rom_seq_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          mode_loop,
  input  logic          step_en,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] C_LAST_ADDR = {AW{1'b1}};

  state_t r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      addr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // stop has no meaning here; start alone decides
          if (start) begin
            addr    <= '0;
            r_state <= FETCH;
          end
        end

        FETCH: begin
          if (stop) begin
            addr       <= '0;
            dout_valid <= 1'b0;
            r_state    <= IDLE;
          end else if (step_en) begin
            dout       <= rom_data;
            dout_valid <= 1'b1;
            r_state    <= HOLD;
          end
        end

        HOLD: begin
          // stop overrides a coincident handshake: the word is dropped as
          // consumed and the address returns to 0
          if (stop) begin
            addr       <= '0;
            dout_valid <= 1'b0;
            r_state    <= IDLE;
          end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            if (addr != C_LAST_ADDR) begin
              addr    <= addr + 1'b1;
              r_state <= FETCH;
            end else if (mode_loop) begin
              addr    <= '0;
              r_state <= FETCH;
            end else begin
              r_state <= DONE;
            end
          end
        end

        DONE: begin
          addr       <= '0;
          dout_valid <= 1'b0;
          r_state    <= IDLE;
        end

        default: begin
          addr       <= '0;
          dout_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Status outputs are pure decodes of the state register
  assign busy = (r_state == FETCH) || (r_state == HOLD);
  assign done = (r_state == DONE);

endmodule : rom_addr_seq
`default_nettype wire

// File: tb/tb_rom_addr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_addr_seq
//  Description : Directed self-checking bench for rom_addr_seq wired to the
//                rom8x4 lab ROM (word i = 2*i).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_addr_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode_loop;
  logic       step_en;
  logic [2:0] addr;
  logic [3:0] rom_data;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  rom_addr_seq #(.AW(3), .DW(4)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .mode_loop  (mode_loop),
    .step_en    (step_en),
    .addr       (addr),
    .rom_data   (rom_data),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .done       (done)
  );

  rom8x4 #(.AW(3), .DW(4)) u_rom (
    .addr (addr),
    .data (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int w;
    bit seen;
    bit stalled;

    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode_loop = 1'b0;
    step_en = 1'b0; dout_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_addr",  addr,       0);
    check("rst_dout",  dout,       0);
    check("rst_valid", dout_valid, 0);
    check("rst_busy",  busy,       0);
    check("rst_done",  done,       0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // ---------------- single pass ----------------
    step_en = 1'b1; dout_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("sp_fetch_busy", busy, 1);
    check("sp_addr0",      addr, 0);
    t = 0; w = 0;
    while (!done && t < 60) begin
      if (dout_valid) begin
        check("sp_word", dout, w * 2);
        w++;
      end
      tick();
      t++;
    end
    check("sp_done_seen",    done, 1);
    check("sp_done_cycle",   t,    16);
    check("sp_busy_at_done", busy, 0);
    check("sp_words",        w,    8);
    tick();
    check("sp_done_width", done, 0);
    check("sp_idle_busy",  busy, 0);

    // ---------------- backpressure at addr 3 ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!(busy && !dout_valid && addr == 3'd3) && t < 40) begin
      tick();
      t++;
    end
    check("bp_reach", (t < 40), 1);
    dout_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_dout",  dout,       6);
      check("bp_valid", dout_valid, 1);
      check("bp_addr",  addr,       3);
      tick();
    end
    dout_ready = 1'b1;
    tick();
    check("bp_next_addr",  addr,       4);
    check("bp_next_valid", dout_valid, 0);
    tick();
    check("bp_next_word",  dout,       8);
    check("bp_next_vld",   dout_valid, 1);
    t = 0;
    while (!done && t < 40) begin
      tick();
      t++;
    end
    check("bp_done_seen", done, 1);
    tick();

    // ---------------- loop mode, then stop at word 4 ----------------
    mode_loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0; w = 0; seen = 1'b0;
    while (w <= 10 && t < 100) begin
      if (done) seen = 1'b1;
      if (dout_valid) begin
        check("lp_word", dout, (w % 8) * 2);
        if (w == 10) begin
          stop = 1'b1;
          dout_ready = 1'b0;
        end
        w++;
      end
      tick();
      t++;
    end
    stop = 1'b0; dout_ready = 1'b1; mode_loop = 1'b0;
    check("lp_words",   w,          11);
    check("lp_no_done", seen,       0);
    check("lp_busy",    busy,       0);
    check("lp_addr",    addr,       0);
    check("lp_valid",   dout_valid, 0);
    check("lp_dout",    dout,       4);
    check("lp_done",    done,       0);

    // ---------------- pacing: step_en 1 cycle in 4 ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0; w = 0;
    while (!done && t < 300) begin
      step_en = ((t % 4) == 3);
      if (dout_valid) begin
        check("pc_word", dout, w * 2);
        w++;
      end
      stalled = busy && !dout_valid && !step_en;
      tick();
      t++;
      if (stalled) check("pc_stall", dout_valid, 0);
    end
    step_en = 1'b1;
    check("pc_done_seen",  done, 1);
    check("pc_words",      w,    8);
    check("pc_done_cycle", t,    33);
    tick();

    // ---------------- priority ----------------
    // start held high while busy must not restart the pass
    start = 1'b1;
    repeat (4) tick();
    check("pr_start_addr",  addr,       1);
    check("pr_start_dout",  dout,       2);
    check("pr_start_valid", dout_valid, 1);
    check("pr_start_busy",  busy,       1);
    start = 1'b0;
    t = 0;
    while (!(dout_valid && addr == 3'd2) && t < 20) begin
      tick();
      t++;
    end
    check("pr_reach", (t < 20), 1);
    // stop together with a handshake (dout_ready is 1)
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("pr_busy",  busy,       0);
    check("pr_addr",  addr,       0);
    check("pr_valid", dout_valid, 0);
    check("pr_done",  done,       0);
    check("pr_dout",  dout,       4);
    tick();
    check("pr_done_after", done, 0);
    check("pr_busy_after", busy, 0);

    // ---------------- async reset mid-HOLD at addr 5 ----------------
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (!(busy && !dout_valid && addr == 3'd5) && t < 40) begin
      tick();
      t++;
    end
    check("ar_reach", (t < 40), 1);
    dout_ready = 1'b0;
    tick();
    check("ar_pre_valid", dout_valid, 1);
    check("ar_pre_dout",  dout,       10);
    #2 rst_n = 1'b0;
    #1;
    check("ar_addr",  addr,       0);
    check("ar_dout",  dout,       0);
    check("ar_valid", dout_valid, 0);
    check("ar_busy",  busy,       0);
    check("ar_done",  done,       0);
    tick();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    tick();
    check("ar_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rom_addr_seq
`default_nettype wire
